multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/ctrl_pkg.sv | 79 +++++++
 rtl/cond_check.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, instruction
// Op codes, data-processing cmd codes, ALUControl codes and ARM condition codes.
// The helper cond_eval maps a condition code and NZCV flags to CondEx.
package ctrl_pkg;

    // FSM state encodings (also exported on the State debug port)
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    // Instruction class, Instr[15:14]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing cmd, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ARM condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Condition evaluation; flags packed as {N, Z, C, V}. NV never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_eval = z;
            COND_NE: cond_eval = ~z;
            COND_CS: cond_eval = c;
            COND_CC: cond_eval = ~c;
            COND_MI: cond_eval = n;
            COND_PL: cond_eval = ~n;
            COND_VS: cond_eval = v;
            COND_VC: cond_eval = ~v;
            COND_HI: cond_eval = c & ~z;
            COND_LS: cond_eval = ~c | z;
            COND_GE: cond_eval = (n == v);
            COND_LT: cond_eval = (n != v);
            COND_GT: cond_eval = ~z & (n == v);
            COND_LE: cond_eval = z | (n != v);
            COND_AL: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// NZCV flag register and condition evaluation. NZ and CV halves load
// independently so logical ops can leave carry/overflow untouched.
module cond_check
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       wr_nz,
    input  logic       wr_cv,
    output logic       cond_ex
);

    logic [3:0] flags_q;

    // Flag register: async clear to FLAGS_INIT, split NZ / CV load enables
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            flags_q <= FLAGS_INIT;
        end else begin
            if (wr_nz) flags_q[3:2] <= alu_flags[3:2];
            if (wr_cv) flags_q[1:0] <= alu_flags[1:0];
        end
    end

    assign cond_ex = cond_eval(cond, flags_q);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM-subset control unit: ten-state FSM plus datapath select decode.
// Optional MOV support is enabled by defining MOV_INSTR_EN.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        MOVInstr,
    output logic [3:0]  State
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       unused_bits;

    assign cond        = Instr[19:16];
    assign op          = Instr[15:14];
    assign funct       = Instr[13:8];
    assign cmd         = funct[4:1];
    // Rn/Rd fields are routed straight to the datapath, not decoded here
    assign unused_bits = ^Instr[7:0];

    logic [3:0] state_q, state_d;
    logic       cond_ex;
    logic       cmd_ok, cmd_cv, cmd_mov;
    logic [1:0] cmd_alu;
    logic       pc_wr, ir_wr, reg_wr, mem_wr, mov_state;
    logic       in_exec, wr_nz, wr_cv;

    // Decode data-processing cmd into ALU op and flag-update class
    always_comb begin
        cmd_ok  = 1'b1;
        cmd_cv  = 1'b0;
        cmd_mov = 1'b0;
        cmd_alu = ALU_ADD;
        case (cmd)
            CMD_ADD: begin cmd_alu = ALU_ADD; cmd_cv = 1'b1; end
            CMD_SUB: begin cmd_alu = ALU_SUB; cmd_cv = 1'b1; end
            CMD_AND: cmd_alu = ALU_AND;
            CMD_ORR: cmd_alu = ALU_ORR;
`ifdef MOV_INSTR_EN
            CMD_MOV: cmd_mov = 1'b1;
`endif
            default: cmd_ok = 1'b0;
        endcase
    end

    // Flags load at the end of EXECUTE* so the next instruction sees them
    assign in_exec = (state_q == EXECUTER) || (state_q == EXECUTEI);
    assign wr_nz   = in_exec & funct[0] & cond_ex & cmd_ok;
    assign wr_cv   = wr_nz & cmd_cv;

    cond_check #(
        .FLAGS_INIT(FLAGS_INIT)
    ) u_cond_check (
        .CLK      (CLK),
        .reset    (reset),
        .cond     (cond),
        .alu_flags(ALUFlags),
        .wr_nz    (wr_nz),
        .wr_cv    (wr_cv),
        .cond_ex  (cond_ex)
    );

    // State register: reset aborts any instruction and returns to FETCH
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state datapath control
    always_comb begin
        state_d    = FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mov_state  = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d = funct[0] ? MEMREAD : MEMWRITE;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_wr    = cond_ex;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_wr = cond_ex;
            end
            EXECUTER, EXECUTEI: begin
                state_d    = ALUWB;
                ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = cmd_alu;
                mov_state  = 1'b1;
            end
            ALUWB: begin
                reg_wr    = cond_ex & cmd_ok;
                mov_state = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_wr     = cond_ex;
            end
            default: state_d = FETCH;
        endcase
    end

    // Write strobes are held low for as long as reset is asserted
    assign PCWrite  = pc_wr & reset;
    assign IRWrite  = ir_wr & reset;
    assign RegWrite = reg_wr & reset;
    assign MemWrite = mem_wr & reset;

    assign MOVInstr = mov_state & cmd_mov;
    assign ImmSrc   = op;
    assign RegSrc   = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each instruction pushes its
// expected per-cycle outputs to a scoreboard queue, then the cycles are run
// and every entry is popped and compared against the DUT.
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXR = 4'd6, S_EXI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9;

    logic        CLK, reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, MOVInstr;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  State;

    multicycle_control_fsm #(
        .FLAGS_INIT(4'b0000)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .MOVInstr  (MOVInstr),
        .State     (State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] strb;     // {PCWrite, IRWrite, RegWrite, MemWrite}
        logic [1:0] aluc;
        logic       aluc_chk;
        logic       mov;
        logic [3:0] imm_reg;  // {ImmSrc, RegSrc}
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Per-state expected {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} and the bits defined there
    logic [5:0] sel_tab [10];
    logic [5:0] mask_tab[10];

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        mk = {cond, op, funct, 4'h0, rd};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [3:0] strb, input logic [1:0] aluc,
                        input logic aluc_chk, input logic mov);
        exp_t e;
        e.st       = st;
        e.strb     = strb;
        e.aluc     = aluc;
        e.aluc_chk = aluc_chk;
        e.mov      = mov;
        e.imm_reg  = {Instr[15:14], (Instr[15:14] == 2'b01) && !Instr[8],
                      Instr[15:14] == 2'b10};
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t       e;
        logic [5:0] sel;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty t=%0t", $time);
            return;
        end
        e   = sb.pop_front();
        sel = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
        check("state", {4'h0, State}, {4'h0, e.st});
        check("strobes", {4'h0, PCWrite, IRWrite, RegWrite, MemWrite}, {4'h0, e.strb});
        if (e.aluc_chk) check("alucontrol", {6'h0, ALUControl}, {6'h0, e.aluc});
        check("movinstr", {7'h0, MOVInstr}, {7'h0, e.mov});
        check("immsrc_regsrc", {4'h0, ImmSrc, RegSrc}, {4'h0, e.imm_reg});
        if (e.st < 4'd10)
            check("selects", {2'b00, sel & mask_tab[e.st]},
                  {2'b00, sel_tab[e.st] & mask_tab[e.st]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            check_now();
            @(negedge CLK);
        end
    endtask

    task automatic fetch_decode();
        push(S_FETCH, 4'b1100, 2'b00, 1'b1, 1'b0);
        push(S_DECODE, 4'b0000, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic dp(input logic [3:0] cond, input logic [5:0] funct, input logic [3:0] fl,
                      input logic exp_rw, input logic [1:0] exp_aluc, input logic exp_mov);
        Instr    = mk(cond, 2'b00, funct, 4'd1);
        ALUFlags = fl;
        fetch_decode();
        push(funct[5] ? S_EXI : S_EXR, 4'b0000, exp_aluc, 1'b1, exp_mov);
        push(S_ALUWB, {2'b00, exp_rw, 1'b0}, 2'b00, 1'b0, exp_mov);
        run(4);
    endtask

    task automatic br(input logic [3:0] cond, input logic exp_pcw);
        Instr = mk(cond, 2'b10, 6'b000000, 4'd0);
        fetch_decode();
        push(S_BRANCH, {exp_pcw, 3'b000}, 2'b00, 1'b1, 1'b0);
        run(3);
    endtask

    task automatic ldr(input logic [3:0] cond, input logic exp_rw);
        Instr = mk(cond, 2'b01, 6'b011001, 4'd2);
        fetch_decode();
        push(S_MEMADR, 4'b0000, 2'b00, 1'b1, 1'b0);
        push(S_MEMREAD, 4'b0000, 2'b00, 1'b0, 1'b0);
        push(S_MEMWB, {2'b00, exp_rw, 1'b0}, 2'b00, 1'b0, 1'b0);
        run(5);
    endtask

    task automatic str(input logic [3:0] cond, input logic exp_mw);
        Instr = mk(cond, 2'b01, 6'b011000, 4'd3);
        fetch_decode();
        push(S_MEMADR, 4'b0000, 2'b00, 1'b1, 1'b0);
        push(S_MEMWRITE, {3'b000, exp_mw}, 2'b00, 1'b0, 1'b0);
        run(4);
    endtask

    initial begin
        sel_tab[0] = 6'b0_1_10_10; mask_tab[0] = 6'b111111;
        sel_tab[1] = 6'b0_1_10_10; mask_tab[1] = 6'b011111;
        sel_tab[2] = 6'b0_0_01_00; mask_tab[2] = 6'b011100;
        sel_tab[3] = 6'b1_0_00_00; mask_tab[3] = 6'b100000;
        sel_tab[4] = 6'b0_0_00_01; mask_tab[4] = 6'b000011;
        sel_tab[5] = 6'b1_0_00_00; mask_tab[5] = 6'b100000;
        sel_tab[6] = 6'b0_0_00_00; mask_tab[6] = 6'b011100;
        sel_tab[7] = 6'b0_0_01_00; mask_tab[7] = 6'b011100;
        sel_tab[8] = 6'b0_0_00_00; mask_tab[8] = 6'b000011;
        sel_tab[9] = 6'b0_0_01_10; mask_tab[9] = 6'b011111;

        // Reset held: FETCH with every write strobe low
        reset    = 1'b0;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        @(negedge CLK);
        #1;
        check("reset_state", {4'h0, State}, 8'h00);
        check("reset_strobes", {4'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        @(negedge CLK);
        reset = 1'b1;

        ldr(4'hE, 1'b1);                                   // LDR: 0,1,2,3,4
        dp(4'hE, 6'b100101, 4'b0100, 1'b1, 2'b01, 1'b0);   // SUBS imm -> flags 0100
        br(4'h0, 1'b1);                                    // BEQ taken
        br(4'h1, 1'b0);                                    // BNE not taken
        str(4'hF, 1'b0);                                   // STR NV: no write
        str(4'hE, 1'b1);                                   // STR AL

        // Op=11: FETCH, DECODE, back to FETCH with no strobes
        Instr = mk(4'hE, 2'b11, 6'b000000, 4'd0);
        fetch_decode();
        run(2);

        dp(4'hE, 6'b001000, 4'b1111, 1'b1, 2'b00, 1'b0);   // ADD, no S: flags kept
        br(4'h0, 1'b1);                                    // Z still 1
        br(4'h2, 1'b0);                                    // C still 0
        dp(4'hE, 6'b000001, 4'b1011, 1'b1, 2'b10, 1'b0);   // ANDS: NZ only -> 1000
        br(4'h4, 1'b1);                                    // MI
        br(4'h2, 1'b0);                                    // CS: C not loaded
        br(4'h6, 1'b0);                                    // VS: V not loaded
        br(4'h0, 1'b0);                                    // EQ
        dp(4'hE, 6'b101001, 4'b0011, 1'b1, 2'b00, 1'b0);   // ADDS imm -> 0011
        br(4'h2, 1'b1);                                    // CS
        br(4'h6, 1'b1);                                    // VS
        br(4'hA, 1'b0);                                    // GE: N!=V
        br(4'h8, 1'b1);                                    // HI
        dp(4'hE, 6'b000011, 4'b1111, 1'b0, 2'b00, 1'b0);   // EOR S unsupported
        br(4'h0, 1'b0);                                    // flags unchanged
        br(4'h4, 1'b0);
        dp(4'hE, 6'b011000, 4'b0000, 1'b1, 2'b11, 1'b0);   // ORR
        dp(4'h0, 6'b001000, 4'b0000, 1'b0, 2'b00, 1'b0);   // ADDEQ, Z=0: no write
`ifdef MOV_INSTR_EN
        dp(4'hE, 6'b111010, 4'b0000, 1'b1, 2'b00, 1'b1);   // MOV imm
`else
        dp(4'hE, 6'b111010, 4'b0000, 1'b0, 2'b00, 1'b0);   // cmd 1101 unsupported
`endif
        br(4'hE, 1'b1);                                    // BAL
        br(4'hF, 1'b0);                                    // NV never

        // Reset asserted in MEMWB: abort, strobes low for 3 cycles, resume at FETCH
        Instr    = mk(4'hE, 2'b01, 6'b011001, 4'd2);
        ALUFlags = 4'h0;
        fetch_decode();
        push(S_MEMADR, 4'b0000, 2'b00, 1'b1, 1'b0);
        push(S_MEMREAD, 4'b0000, 2'b00, 1'b0, 1'b0);
        push(S_MEMWB, 4'b0010, 2'b00, 1'b0, 1'b0);
        run(4);
        check_now();
        reset = 1'b0;
        #1;
        check("midrst_state", {4'h0, State}, 8'h00);
        check("midrst_regwrite", {7'h0, RegWrite}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check("midrst_hold_state", {4'h0, State}, 8'h00);
            check("midrst_hold_strobes", {4'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 8'h00);
        end
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("release_state", {4'h0, State}, 8'h00);
        check("release_irwrite", {7'h0, IRWrite}, 8'h01);
        br(4'h0, 1'b0);                                    // flags back to FLAGS_INIT
        br(4'h1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
